// File: rtl/axis_ins_pkg.sv
// rtl/axis_ins_pkg.sv - shared state encoding, counter width and round-robin pick helper
package axis_ins_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam int PKT_CNT_WD = 16;
  localparam int MAX_SRC    = 16;
  localparam int MAX_SRC_WD = 4;

  // n is the live requester count; scanning from the top keeps the nearest index after ptr
  function automatic logic [MAX_SRC_WD-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                    input logic [MAX_SRC_WD-1:0] ptr,
                                                    input int n);
    logic [MAX_SRC_WD-1:0] pick;
    int idx;
    pick = ptr;
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[MAX_SRC_WD-1:0]]) pick = MAX_SRC_WD'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after ptr
module rr_arbiter
  import axis_ins_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_ID_WD-1:0] ptr,
  output logic [SRC_ID_WD-1:0] idx,
  output logic                 any
);

  logic [MAX_SRC-1:0]    req_ext;
  logic [MAX_SRC_WD-1:0] ptr_ext;
  logic [MAX_SRC_WD-1:0] pick;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_SRC-1:0] = req;
    ptr_ext = '0;
    ptr_ext[SRC_ID_WD-1:0] = ptr;
    pick = rr_pick(req_ext, ptr_ext, NUM_SRC);
  end

  assign idx = pick[SRC_ID_WD-1:0];
  assign any = |req;

endmodule

// File: rtl/axis_header_insert_arbiter.sv
// rtl/axis_header_insert_arbiter.sv - packet-granular round-robin mux of header+payload streams
// AXIS_ARB_PKT_CNT_EN adds per-source completed-packet counters on pkt_cnt.
module axis_header_insert_arbiter
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic [NUM_SRC-1:0]              s_ready,
  input  logic [NUM_SRC-1:0]              h_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      h_header,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] h_keep,
  output logic [NUM_SRC-1:0]              h_ready,
  output logic                            m_valid,
  output logic [DATA_WD-1:0]              m_data,
  output logic [DATA_BYTE_WD-1:0]         m_keep,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic                            mh_valid,
  output logic [DATA_WD-1:0]              mh_header,
  output logic [DATA_BYTE_WD-1:0]         mh_keep,
  input  logic                            mh_ready,
  output logic [SRC_ID_WD-1:0]            grant_id,
`ifdef AXIS_ARB_PKT_CNT_EN
  output logic [NUM_SRC*PKT_CNT_WD-1:0]   pkt_cnt,
`endif
  output logic                            busy
);

  arb_state_e           state, state_nxt;
  logic [SRC_ID_WD-1:0] rr_ptr;
  logic [SRC_ID_WD-1:0] pick_idx;
  logic                 pick_any;
  logic                 hdr_done;
  logic                 pkt_done;

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .SRC_ID_WD(SRC_ID_WD)
  ) u_rr (
    .req(h_valid),
    .ptr(rr_ptr),
    .idx(pick_idx),
    .any(pick_any)
  );

  // Fields always follow the granted source so idle outputs never mux X
  assign m_data    = s_data[int'(grant_id)*DATA_WD +: DATA_WD];
  assign m_keep    = s_keep[int'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign m_last    = s_last[grant_id];
  assign mh_header = h_header[int'(grant_id)*DATA_WD +: DATA_WD];
  assign mh_keep   = h_keep[int'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign busy      = (state != ARB_IDLE);

  assign hdr_done = (state == ARB_HDR) && h_valid[grant_id] && mh_ready;
  assign pkt_done = (state == ARB_DATA) && s_valid[grant_id] && m_ready && s_last[grant_id];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      rr_ptr   <= SRC_ID_WD'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_any) grant_id <= pick_idx;
      if (pkt_done) rr_ptr <= grant_id;
    end
  end

  always_comb begin
    state_nxt = state;
    mh_valid  = 1'b0;
    m_valid   = 1'b0;
    h_ready   = '0;
    s_ready   = '0;
    case (state)
      ARB_IDLE: if (pick_any) state_nxt = ARB_HDR;
      ARB_HDR: begin
        mh_valid          = h_valid[grant_id];
        h_ready[grant_id] = mh_ready;
        if (hdr_done) state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        m_valid           = s_valid[grant_id];
        s_ready[grant_id] = m_ready;
        if (pkt_done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (pkt_done) begin
      pkt_cnt[int'(grant_id)*PKT_CNT_WD +: PKT_CNT_WD] <=
        pkt_cnt[int'(grant_id)*PKT_CNT_WD +: PKT_CNT_WD] + PKT_CNT_WD'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_header_insert_arbiter.sv
// tb/tb_axis_header_insert_arbiter.sv - randomized scoreboard bench for axis_header_insert_arbiter
module tb_axis_header_insert_arbiter;

  localparam int DW = 32, BW = 4, NS = 4, IW = 2, MAXP = 4, MAXB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     s_valid, s_last, s_ready, h_valid, h_ready;
  logic [NS*DW-1:0]  s_data, h_header;
  logic [NS*BW-1:0]  s_keep, h_keep;
  logic              m_valid, m_last, m_ready, mh_valid, mh_ready, busy;
  logic [DW-1:0]     m_data, mh_header;
  logic [BW-1:0]     m_keep, mh_keep;
  logic [IW-1:0]     grant_id;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NS*16-1:0]  pkt_cnt;
  int                exp_cnt[NS];
`endif

  axis_header_insert_arbiter #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
    .h_valid(h_valid), .h_header(h_header), .h_keep(h_keep), .h_ready(h_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_ready(m_ready),
    .mh_valid(mh_valid), .mh_header(mh_header), .mh_keep(mh_keep), .mh_ready(mh_ready),
    .grant_id(grant_id),
`ifdef AXIS_ARB_PKT_CNT_EN
    .pkt_cnt(pkt_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Per-source packet tables
  logic [DW-1:0] hdr_t[NS][MAXP];
  logic [BW-1:0] hkeep_t[NS][MAXP];
  int            len_t[NS][MAXP];
  logic [DW-1:0] dat_t[NS][MAXP][MAXB];
  logic [BW-1:0] keep_t[NS][MAXP][MAXB];
  int            npkt[NS];

  int cp[NS], cb[NS];
  bit hdr_sent[NS], hs_h[NS], hs_s[NS];

  typedef struct { int src; int pkt; } exp_t;
  exp_t exp_q[$];

  int errors, checks;
  bit mon_en, drv_en, mon_hdr_done, prev_last, prev_req_idle;
  int mon_beat, g, p;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic zero_inputs();
    s_valid = '0; s_last = '0; s_data = '0; s_keep = '0;
    h_valid = '0; h_header = '0; h_keep = '0;
    m_ready = 1'b0; mh_ready = 1'b0;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NS; i++) npkt[i] = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NS; i++) begin
      npkt[i] = int'($urandom_range(0, 3));
      for (int q = 0; q < MAXP; q++) begin
        hdr_t[i][q]   = $urandom;
        hkeep_t[i][q] = BW'($urandom);
        len_t[i][q]   = int'($urandom_range(1, MAXB));
        for (int b = 0; b < MAXB; b++) begin
          dat_t[i][q][b]  = $urandom;
          keep_t[i][q][b] = BW'($urandom);
        end
      end
    end
  endtask

  // Round-robin order over sources that still hold packets, starting after source NS-1
  task automatic build_expected();
    int rem[NS];
    int nxt[NS];
    int last;
    int total;
    last = NS - 1;
    total = 0;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin rem[i] = npkt[i]; nxt[i] = 0; total += npkt[i]; end
    while (total > 0) begin
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (last + k) % NS;
        if (rem[s] > 0) begin
          exp_q.push_back('{src: s, pkt: nxt[s]});
          nxt[s]++; rem[s]--; total--; last = s;
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_grant", 64'(grant_id), 64'(0));
    chk("reset_readies", 64'({s_ready, h_ready}), 64'(0));
    chk("reset_valids", 64'({m_valid, mh_valid}), 64'(0));
    rst_n = 1'b1;
`ifdef AXIS_ARB_PKT_CNT_EN
    for (int i = 0; i < NS; i++) exp_cnt[i] = 0;
`endif
  endtask

  task automatic run_scenario();
    build_expected();
    for (int i = 0; i < NS; i++) begin cp[i] = 0; cb[i] = 0; hdr_sent[i] = 0; end
    mon_beat = 0; mon_hdr_done = 0; prev_last = 0; prev_req_idle = 0;
    mon_en = 1; drv_en = 1;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
    chk("scenario_drain", 64'(exp_q.size()), 64'(0));
    #2;
    drv_en = 0;
    zero_inputs();
    @(negedge clk);
    #1;
    mon_en = 0;
`ifdef AXIS_ARB_PKT_CNT_EN
    for (int i = 0; i < NS; i++) chk("pkt_cnt", 64'(pkt_cnt[i*16 +: 16]), 64'(exp_cnt[i]));
`endif
    exp_q.delete();
  endtask

  // Source model: holds valid until handshake, presents the next packet right after the last beat
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      mh_ready = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NS; i++) begin
        if (hs_h[i]) hdr_sent[i] = 1;
        if (hs_s[i]) begin
          cb[i]++;
          if (cb[i] >= len_t[i][cp[i]]) begin cp[i]++; cb[i] = 0; hdr_sent[i] = 0; end
        end
        if (cp[i] < npkt[i]) begin
          h_valid[i] = !hdr_sent[i];
          h_header[i*DW +: DW] = hdr_t[i][cp[i]];
          h_keep[i*BW +: BW]   = hkeep_t[i][cp[i]];
          if (!s_valid[i] || hs_s[i]) s_valid[i] = ($urandom_range(0, 3) != 0);
          s_data[i*DW +: DW] = dat_t[i][cp[i]][cb[i]];
          s_keep[i*BW +: BW] = keep_t[i][cp[i]][cb[i]];
          s_last[i] = (cb[i] == len_t[i][cp[i]] - 1);
        end else begin
          h_valid[i] = 0; s_valid[i] = 0; s_last[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      hs_h[i] = h_valid[i] && h_ready[i];
      hs_s[i] = s_valid[i] && s_ready[i];
    end
    if (mon_en) begin
      if (prev_last) chk("idle_after_last", 64'(busy), 64'(0));
      if (prev_req_idle) chk("hdr_latency", 64'(mh_valid), 64'(1));
      if (exp_q.size() == 0) begin
        chk("ready_when_drained", 64'({s_ready, h_ready}), 64'(0));
        if (mh_valid || m_valid) chk("unexpected_output", 64'({mh_valid, m_valid}), 64'(0));
      end else begin
        g = exp_q[0].src;
        p = exp_q[0].pkt;
        chk("s_ready_other", 64'(s_ready & ~(NS'(1) << g)), 64'(0));
        chk("h_ready_other", 64'(h_ready & ~(NS'(1) << g)), 64'(0));
        if (mh_valid) begin
          chk("hdr_phase", 64'(mon_hdr_done), 64'(0));
          chk("hdr_grant", 64'(grant_id), 64'(g));
          chk("hdr_data", 64'(mh_header), 64'(hdr_t[g][p]));
          chk("hdr_keep", 64'(mh_keep), 64'(hkeep_t[g][p]));
          chk("h_ready_g", 64'(h_ready[g]), 64'(mh_ready));
          chk("m_valid_in_hdr", 64'(m_valid), 64'(0));
          if (mh_ready) mon_hdr_done = 1;
        end
        if (m_valid) begin
          chk("data_phase", 64'(mon_hdr_done), 64'(1));
          chk("s_ready_g", 64'(s_ready[g]), 64'(m_ready));
          if (m_ready) begin
            chk("beat_data", 64'(m_data), 64'(dat_t[g][p][mon_beat]));
            chk("beat_keep", 64'(m_keep), 64'(keep_t[g][p][mon_beat]));
            chk("beat_last", 64'(m_last), 64'(mon_beat == len_t[g][p] - 1));
            if (mon_beat >= len_t[g][p] - 1) begin
              void'(exp_q.pop_front());
              mon_beat = 0;
              mon_hdr_done = 0;
`ifdef AXIS_ARB_PKT_CNT_EN
              exp_cnt[g] = (exp_cnt[g] + 1) % 65536;
`endif
            end else begin
              mon_beat++;
            end
          end
        end
      end
      prev_last     = m_valid && m_ready && m_last;
      prev_req_idle = !busy && (|h_valid);
    end
  end

  task automatic directed_stall_reset();
    @(negedge clk);
    h_valid = 4'b0010;
    h_header[DW +: DW] = 32'h1111_2222;
    h_keep[BW +: BW] = 4'hF;
    mh_ready = 0; m_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) h_valid[0] = 1'b1;
      chk("stall_grant", 64'(grant_id), 64'(1));
      chk("stall_busy", 64'(busy), 64'(1));
      chk("stall_mh_valid", 64'(mh_valid), 64'(1));
      chk("stall_h_ready", 64'(h_ready), 64'(0));
    end
    mh_ready = 1;
    @(negedge clk);
    h_valid = 4'b0001; mh_ready = 0;
    s_valid[1] = 1; s_data[DW +: DW] = 32'h0000_00D0; s_keep[BW +: BW] = 4'hF; s_last[1] = 0;
    m_ready = 1;
    #1;
    chk("beat0_grant", 64'(grant_id), 64'(1));
    chk("beat0_s_ready", 64'(s_ready), 64'(4'b0010));
    @(negedge clk);
    s_data[DW +: DW] = 32'h0000_00D1;
    #1;
    chk("beat1_data", 64'(m_data), 64'(32'h0000_00D1));
    chk("beat1_s_ready", 64'(s_ready), 64'(4'b0010));
    rst_n = 0;
    @(negedge clk);
    chk("midpkt_reset_busy", 64'(busy), 64'(0));
    chk("midpkt_reset_readies", 64'({s_ready, h_ready}), 64'(0));
    chk("midpkt_reset_valids", 64'({m_valid, mh_valid}), 64'(0));
    rst_n = 1; s_valid = '0; m_ready = 0; h_valid = 4'b1111;
    @(negedge clk);
    chk("post_reset_grant", 64'(grant_id), 64'(0));
    chk("post_reset_mh_valid", 64'(mh_valid), 64'(1));
    zero_inputs();
`ifdef AXIS_ARB_PKT_CNT_EN
    for (int i = 0; i < NS; i++) exp_cnt[i] = 0;
`endif
  endtask

  initial begin
    errors = 0; checks = 0; mon_en = 0; drv_en = 0; rst_n = 0;
    zero_inputs();

    clear_tables();
    npkt[2] = 1; hdr_t[2][0] = 32'hAABB_CCDD; hkeep_t[2][0] = 4'hF; len_t[2][0] = 3;
    for (int b = 0; b < MAXB; b++) begin dat_t[2][0][b] = 32'h1000 + b; keep_t[2][0][b] = 4'hF; end
    do_reset();
    run_scenario();

    clear_tables();
    for (int i = 0; i < NS; i++) begin
      npkt[i] = (i == 0) ? 2 : 1;
      for (int q = 0; q < 2; q++) begin
        hdr_t[i][q] = 32'hA000 + i * 16 + q; hkeep_t[i][q] = 4'hF; len_t[i][q] = 1;
        dat_t[i][q][0] = 32'hB000 + i * 16 + q; keep_t[i][q][0] = 4'h3;
      end
    end
    do_reset();
    run_scenario();

    directed_stall_reset();

    repeat (6) begin
      fill_random();
      do_reset();
      run_scenario();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
